// File: rtl/spmp_csr_regs_pkg.sv
// spmp_csr_regs_pkg: shared types, CSR map and address decode for the SPMP
// configuration register block.
package spmp_csr_regs_pkg;

  // Core configuration subset this block depends on.
  typedef struct packed {
    int unsigned NrSPMPEntries;
    int unsigned PLEN;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '{NrSPMPEntries: 32'd16, PLEN: 32'd34};

  typedef enum logic [2:0] {
    ACCESS_NONE  = 3'b000,
    ACCESS_READ  = 3'b001,
    ACCESS_WRITE = 3'b010,
    ACCESS_EXEC  = 3'b100
  } pmp_access_t;

  typedef enum logic [1:0] {
    SPMP_OFF   = 2'b00,
    SPMP_TOR   = 2'b01,
    SPMP_NA4   = 2'b10,
    SPMP_NAPOT = 2'b11
  } spmp_addr_mode_t;

  // One cfg byte: bit7 S, bits6:5 reserved (always 0), bits4:3 mode, X/W/R.
  typedef struct packed {
    logic            s;
    logic [1:0]      rsvd;
    spmp_addr_mode_t addr_mode;
    logic            x;
    logic            w;
    logic            r;
  } spmpcfg_t;

  localparam logic [11:0] CSR_SPMPCFG0   = 12'h1A0;
  localparam logic [11:0] CSR_SPMPADDR0  = 12'h1B0;
  localparam logic [11:0] CSR_SPMPSWITCH = 12'h170;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_RESP  = 2'd2
  } spmp_state_t;

  typedef enum logic [1:0] {
    CSR_KIND_NONE   = 2'd0,
    CSR_KIND_CFG    = 2'd1,
    CSR_KIND_ADDR   = 2'd2,
    CSR_KIND_SWITCH = 2'd3
  } csr_kind_t;

  // For CFG, idx[2:0] is the cfg group (entries 8*idx..8*idx+7);
  // for ADDR, idx is the entry number.
  typedef struct packed {
    csr_kind_t  kind;
    logic [5:0] idx;
  } csr_sel_t;

  function automatic csr_sel_t csr_decode(input logic [11:0] addr);
    csr_sel_t   sel;
    logic [3:0] cfg_off;
    logic [5:0] addr_off;
    sel.kind = CSR_KIND_NONE;
    sel.idx  = '0;
    cfg_off  = 4'(addr - CSR_SPMPCFG0);
    addr_off = 6'(addr - CSR_SPMPADDR0);
    if (addr >= CSR_SPMPCFG0 && addr < CSR_SPMPCFG0 + 12'd16) begin
      // Odd spmpcfg indices do not exist on RV64.
      if (!cfg_off[0]) begin
        sel.kind = CSR_KIND_CFG;
        sel.idx  = {3'b000, cfg_off[3:1]};
      end
    end else if (addr >= CSR_SPMPADDR0 && addr < CSR_SPMPADDR0 + 12'd64) begin
      sel.kind = CSR_KIND_ADDR;
      sel.idx  = addr_off;
    end else if (addr == CSR_SPMPSWITCH) begin
      sel.kind = CSR_KIND_SWITCH;
    end
    return sel;
  endfunction

endpackage

// File: rtl/spmp_cfg_warl.sv
// spmp_cfg_warl: legalizes one cfg byte write. The reserved encoding
// S=1/XWR=000 keeps the old value; otherwise the new byte is taken with
// its reserved bits forced to zero.
module spmp_cfg_warl
  import spmp_csr_regs_pkg::*;
(
  input  spmpcfg_t   cfg_old,
  input  logic [7:0] cfg_new,
  output spmpcfg_t   cfg_legal
);

  spmpcfg_t cfg_wr;

  // Pick the old or cleaned-up new value.
  always_comb begin
    cfg_wr      = spmpcfg_t'(cfg_new);
    cfg_wr.rsvd = 2'b00;
    if (cfg_wr.s && !cfg_wr.x && !cfg_wr.w && !cfg_wr.r) begin
      cfg_legal = cfg_old;
    end else begin
      cfg_legal = cfg_wr;
    end
  end

endmodule

// File: rtl/spmp_csr_regs.sv
// spmp_csr_regs: SPMP CSR register file (spmpcfg, spmpaddr, spmpswitch)
// with a request/response CSR port and a downstream flush request.
// Build option: define SPMP_FLUSH_HANDSHAKE_EN to wait for flush_ack_i in a
// FLUSH state; otherwise flush_req_o pulses alongside the response.
//
// state | meaning
// IDLE  | ready for a CSR access, writes commit on acceptance
// FLUSH | effective write done, holding flush_req_o until flush_ack_i
// RESP  | one-cycle response pulse, then back to IDLE
module spmp_csr_regs
  import spmp_csr_regs_pkg::*;
#(
  parameter cva6_cfg_t CVA6Cfg = cva6_cfg_empty,
  localparam int NrEntries = int'(CVA6Cfg.NrSPMPEntries),
  localparam int NrOut     = (NrEntries == 0) ? 1 : NrEntries,
  localparam int AddrW     = int'(CVA6Cfg.PLEN) - 2
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          csr_valid_i,
  output logic                          csr_ready_o,
  input  logic                          csr_we_i,
  input  logic [11:0]                   csr_addr_i,
  input  logic [63:0]                   csr_wdata_i,
  output logic                          csr_rsp_valid_o,
  output logic [63:0]                   csr_rdata_o,
  output logic                          csr_err_o,
  output logic                          flush_req_o,
  input  logic                          flush_ack_i,
  output spmpcfg_t [NrOut-1:0]          spmpcfg_o,
  output logic [NrOut-1:0][AddrW-1:0]   spmpaddr_o,
  output logic [63:0]                   spmpswitch_o
);

  // Enable bits exist only for implemented entries.
  localparam logic [63:0] SwitchMask =
    (NrEntries >= 64) ? {64{1'b1}} : ((64'd1 << NrEntries) - 64'd1);

  spmp_state_t                  state_q;
  logic                         rsp_valid_q;
  logic                         flush_req_q;
  logic                         err_q;
  logic [63:0]                  rdata_q;

  spmpcfg_t [NrOut-1:0]         cfg_q;
  spmpcfg_t [NrOut-1:0]         cfg_d;
  spmpcfg_t [NrOut-1:0]         cfg_legal;
  logic [NrOut-1:0][AddrW-1:0]  addr_q;
  logic [NrOut-1:0][AddrW-1:0]  addr_d;
  logic [63:0]                  switch_q;
  logic [63:0]                  switch_d;

  csr_sel_t                     sel;
  logic                         accept;
  logic                         wr_en;
  logic                         illegal;
  logic                         changed;
  logic [63:0]                  rd_value;

  assign sel     = csr_decode(csr_addr_i);
  assign illegal = (sel.kind == CSR_KIND_NONE);
  assign accept  = csr_valid_i & csr_ready_o;
  assign wr_en   = accept & csr_we_i & ~illegal;

  // Each entry's byte sits at a fixed lane of the spmpcfg word it lives in.
  for (genvar e = 0; e < NrEntries; e++) begin : g_warl
    spmp_cfg_warl u_warl (
      .cfg_old  (cfg_q[e]),
      .cfg_new  (csr_wdata_i[8*(e%8) +: 8]),
      .cfg_legal(cfg_legal[e])
    );
  end
  if (NrEntries == 0) begin : g_no_entries
    assign cfg_legal = '0;
  end

  // Next register state after the accepted write (if any).
  always_comb begin
    cfg_d    = cfg_q;
    addr_d   = addr_q;
    switch_d = switch_q;
    if (wr_en) begin
      for (int e = 0; e < NrEntries; e++) begin
        if (sel.kind == CSR_KIND_CFG && sel.idx[2:0] == 3'(e / 8)) begin
          cfg_d[e] = cfg_legal[e];
        end
        if (sel.kind == CSR_KIND_ADDR && sel.idx == 6'(e)) begin
          addr_d[e] = csr_wdata_i[AddrW-1:0];
        end
      end
      if (sel.kind == CSR_KIND_SWITCH) begin
        switch_d = csr_wdata_i & SwitchMask;
      end
    end
  end

  assign changed = (cfg_d != cfg_q) || (addr_d != addr_q) || (switch_d != switch_q);

  // Read data comes from the post-write values so a write returns what stuck.
  always_comb begin
    rd_value = '0;
    case (sel.kind)
      CSR_KIND_CFG: begin
        for (int e = 0; e < NrEntries; e++) begin
          if (sel.idx[2:0] == 3'(e / 8)) begin
            rd_value[8*(e%8) +: 8] = cfg_d[e];
          end
        end
      end
      CSR_KIND_ADDR: begin
        for (int e = 0; e < NrEntries; e++) begin
          if (sel.idx == 6'(e)) begin
            rd_value[AddrW-1:0] = addr_d[e];
          end
        end
      end
      CSR_KIND_SWITCH: rd_value = switch_d;
      default:         rd_value = '0;
    endcase
  end

  // Architectural register storage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cfg_q    <= '0;
      addr_q   <= '0;
      switch_q <= '0;
    end else begin
      cfg_q    <= cfg_d;
      addr_q   <= addr_d;
      switch_q <= switch_d;
    end
  end

`ifndef SPMP_FLUSH_HANDSHAKE_EN
  logic unused_flush_ack;
  assign unused_flush_ack = flush_ack_i;
`endif

  // Transaction FSM with registered response and flush outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      rsp_valid_q <= 1'b0;
      flush_req_q <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          rsp_valid_q <= 1'b0;
          flush_req_q <= 1'b0;
          if (accept) begin
            rdata_q <= rd_value;
            err_q   <= illegal;
`ifdef SPMP_FLUSH_HANDSHAKE_EN
            if (changed) begin
              state_q     <= ST_FLUSH;
              flush_req_q <= 1'b1;
            end else begin
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
            end
`else
            state_q     <= ST_RESP;
            rsp_valid_q <= 1'b1;
            flush_req_q <= changed;
`endif
          end
        end
`ifdef SPMP_FLUSH_HANDSHAKE_EN
        ST_FLUSH: begin
          if (flush_ack_i) begin
            state_q     <= ST_RESP;
            flush_req_q <= 1'b0;
            rsp_valid_q <= 1'b1;
          end
        end
`endif
        ST_RESP: begin
          state_q     <= ST_IDLE;
          rsp_valid_q <= 1'b0;
          flush_req_q <= 1'b0;
        end
        default: begin
          state_q     <= ST_IDLE;
          rsp_valid_q <= 1'b0;
          flush_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign csr_ready_o     = (state_q == ST_IDLE);
  assign csr_rsp_valid_o = rsp_valid_q;
  assign csr_rdata_o     = rdata_q;
  assign csr_err_o       = err_q;
  assign flush_req_o     = flush_req_q;
  assign spmpcfg_o       = cfg_q;
  assign spmpaddr_o      = addr_q;
  assign spmpswitch_o    = switch_q;

endmodule

// File: tb/tb_spmp_csr_regs.sv
// tb_spmp_csr_regs: directed and randomized checks of spmp_csr_regs against
// a behavioural model of the CSR map, WARL and response/flush timing.
// Honours SPMP_FLUSH_HANDSHAKE_EN to pick the expected flush timing.
module tb_spmp_csr_regs;
  import spmp_csr_regs_pkg::*;

  localparam int N  = 16;
  localparam int PL = 34;
  localparam int AW = PL - 2;
  localparam cva6_cfg_t TB_CFG = '{NrSPMPEntries: N, PLEN: PL};
  localparam logic [63:0] AMASK  = (64'd1 << AW) - 64'd1;
  localparam logic [63:0] SWMASK = (64'd1 << N) - 64'd1;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    csr_valid;
  logic                    csr_ready;
  logic                    csr_we;
  logic [11:0]             csr_addr;
  logic [63:0]             csr_wdata;
  logic                    csr_rsp_valid;
  logic [63:0]             csr_rdata;
  logic                    csr_err;
  logic                    flush_req;
  logic                    flush_ack;
  spmpcfg_t [N-1:0]        cfg_o;
  logic [N-1:0][AW-1:0]    addr_o;
  logic [63:0]             sw_o;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  m_cfg  [64];
  logic [63:0] m_addr [64];
  logic [63:0] m_sw;

  spmp_csr_regs #(.CVA6Cfg(TB_CFG)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .csr_valid_i    (csr_valid),
    .csr_ready_o    (csr_ready),
    .csr_we_i       (csr_we),
    .csr_addr_i     (csr_addr),
    .csr_wdata_i    (csr_wdata),
    .csr_rsp_valid_o(csr_rsp_valid),
    .csr_rdata_o    (csr_rdata),
    .csr_err_o      (csr_err),
    .flush_req_o    (flush_req),
    .flush_ack_i    (flush_ack),
    .spmpcfg_o      (cfg_o),
    .spmpaddr_o     (addr_o),
    .spmpswitch_o   (sw_o)
  );

  always #5 clk = ~clk;

  function automatic void model_clear();
    for (int i = 0; i < 64; i++) begin
      m_cfg[i]  = '0;
      m_addr[i] = '0;
    end
    m_sw = '0;
  endfunction

  function automatic void model_access(input bit we, input logic [11:0] a, input logic [63:0] wd,
                                       output logic [63:0] rd, output bit err, output bit ch);
    int off, ent;
    logic [7:0]  nb;
    logic [63:0] v;
    rd = '0; err = 0; ch = 0;
    if (a >= CSR_SPMPCFG0 && a < CSR_SPMPCFG0 + 12'd16) begin
      off = int'(a - CSR_SPMPCFG0);
      if (off % 2 == 1) err = 1;
      else begin
        for (int b = 0; b < 8; b++) begin
          ent = (off / 2) * 8 + b;
          nb  = wd[8*b +: 8];
          if (we && ent < N && !(nb[7] && nb[2:0] == 3'b000)) begin
            if ((nb & 8'h9F) != m_cfg[ent]) ch = 1;
            m_cfg[ent] = nb & 8'h9F;
          end
          if (ent < N) rd[8*b +: 8] = m_cfg[ent];
        end
      end
    end else if (a >= CSR_SPMPADDR0 && a < CSR_SPMPADDR0 + 12'd64) begin
      off = int'(a - CSR_SPMPADDR0);
      if (we && off < N) begin
        v = wd & AMASK;
        if (v != m_addr[off]) ch = 1;
        m_addr[off] = v;
      end
      if (off < N) rd = m_addr[off];
    end else if (a == CSR_SPMPSWITCH) begin
      if (we) begin
        v  = wd & SWMASK;
        ch = (v != m_sw);
        m_sw = v;
      end
      rd = m_sw;
    end else begin
      err = 1;
    end
  endfunction

  function automatic bit outputs_match();
    for (int e = 0; e < N; e++) begin
      if (cfg_o[e] !== m_cfg[e]) return 0;
      if (addr_o[e] !== m_addr[e][AW-1:0]) return 0;
    end
    return (sw_o === m_sw);
  endfunction

  function automatic int exp_lat(input bit ch, input int d);
`ifdef SPMP_FLUSH_HANDSHAKE_EN
    return ch ? d + 1 : 1;
`else
    return (ch && d < 0) ? 0 : 1;
`endif
  endfunction

  function automatic int exp_fl(input bit ch, input int d);
`ifdef SPMP_FLUSH_HANDSHAKE_EN
    return ch ? d : 0;
`else
    return (ch && d >= 0) ? 1 : 0;
`endif
  endfunction

  // One CSR transaction; returns observations only.
  task automatic xact(input bit we, input logic [11:0] a, input logic [63:0] wd, input int ack_delay,
                      output logic [63:0] rd, output logic err, output int lat, output int fl,
                      output bit to, output bit one_shot);
    rd = '0; err = 0; lat = 0; fl = 0; to = 1; one_shot = 0;
    @(negedge clk);
    for (int w = 0; w < 20 && !csr_ready; w++) @(negedge clk);
    csr_valid = 1; csr_we = we; csr_addr = a; csr_wdata = wd;
    @(posedge clk);
    #1 csr_valid = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (flush_req) fl++;
      if (csr_rsp_valid) begin
        lat = k; rd = csr_rdata; err = csr_err; to = 0;
        break;
      end
      flush_ack = (flush_req && fl >= ack_delay);
    end
    flush_ack = 0;
    @(negedge clk);
    one_shot = !csr_rsp_valid && csr_ready;
  endtask

  task automatic test_reset();
    logic [63:0] rd; logic err; int lat, fl; bit to, os;
    @(negedge clk);
    checks++;
    if (csr_rsp_valid !== 0 || flush_req !== 0 || csr_err !== 0 || csr_rdata !== 0) begin
      failures++;
      $display("FAIL reset_ctrl rsp=%0b flush=%0b err=%0b rdata=%h want all 0", csr_rsp_valid, flush_req, csr_err, csr_rdata);
    end
    checks++;
    if (cfg_o !== '0 || addr_o !== '0 || sw_o !== 0) begin
      failures++;
      $display("FAIL reset_regs cfg=%h addr=%h sw=%h want 0", cfg_o, addr_o, sw_o);
    end
    rst_n = 1;
    @(negedge clk);
    checks++;
    if (csr_ready !== 1) begin
      failures++;
      $display("FAIL reset_ready got=%0b want=1", csr_ready);
    end
    xact(0, CSR_SPMPSWITCH, 64'h0, 1, rd, err, lat, fl, to, os);
    checks++;
    if (to || lat !== 1 || rd !== 0 || err !== 0) begin
      failures++;
      $display("FAIL reset_read_switch to=%0b lat=%0d rdata=%h err=%0b want lat=1 rdata=0 err=0", to, lat, rd, err);
    end
  endtask

  task automatic test_cfg_write();
    logic [63:0] rd, mrd; logic err; int lat, fl; bit to, os, merr, mch;
    model_access(1, CSR_SPMPCFG0, 64'h8F0B, mrd, merr, mch);
    xact(1, CSR_SPMPCFG0, 64'h8F0B, 3, rd, err, lat, fl, to, os);
    checks++;
    if (cfg_o[0] !== 8'h0B || cfg_o[1] !== 8'h8F) begin
      failures++;
      $display("FAIL cfg0_entries e0=%h e1=%h want 0b 8f", cfg_o[0], cfg_o[1]);
    end
    checks++;
    if (to || lat !== exp_lat(1, 3) || fl !== exp_fl(1, 3)) begin
      failures++;
      $display("FAIL cfg0_flush to=%0b lat=%0d flush=%0d want lat=%0d flush=%0d", to, lat, fl, exp_lat(1, 3), exp_fl(1, 3));
    end
    checks++;
    if (rd !== 64'h8F0B || err !== 0) begin
      failures++;
      $display("FAIL cfg0_rdata got=%h err=%0b want 8f0b err=0", rd, err);
    end
  endtask

  task automatic test_warl();
    logic [63:0] rd, mrd; logic err; int lat, fl; bit to, os, merr, mch;
    model_access(1, CSR_SPMPCFG0, 64'h001B_8F0B, mrd, merr, mch);
    xact(1, CSR_SPMPCFG0, 64'h001B_8F0B, 1, rd, err, lat, fl, to, os);
    model_access(1, CSR_SPMPCFG0, 64'hE180_0C0D, mrd, merr, mch);
    xact(1, CSR_SPMPCFG0, 64'hE180_0C0D, 2, rd, err, lat, fl, to, os);
    checks++;
    if (cfg_o[2] !== 8'h1B || cfg_o[0] !== 8'h0D || cfg_o[1] !== 8'h0C || cfg_o[3] !== 8'h81) begin
      failures++;
      $display("FAIL warl_entries e0=%h e1=%h e2=%h e3=%h want 0d 0c 1b 81", cfg_o[0], cfg_o[1], cfg_o[2], cfg_o[3]);
    end
    checks++;
    if (rd !== 64'h811B_0C0D || rd !== mrd) begin
      failures++;
      $display("FAIL warl_rdata got=%h want=%h", rd, mrd);
    end
  endtask

  task automatic test_addr();
    logic [63:0] rd, mrd; logic err; int lat, fl; bit to, os, merr, mch;
    model_access(1, CSR_SPMPADDR0, '1, mrd, merr, mch);
    xact(1, CSR_SPMPADDR0, '1, 2, rd, err, lat, fl, to, os);
    checks++;
    if (rd !== 64'h0000_0000_FFFF_FFFF || addr_o[0] !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL addr0_mask rdata=%h out=%h want 00000000ffffffff", rd, addr_o[0]);
    end
    model_access(1, CSR_SPMPADDR0 + 12'd20, 64'h55, mrd, merr, mch);
    xact(1, CSR_SPMPADDR0 + 12'd20, 64'h55, 1, rd, err, lat, fl, to, os);
    checks++;
    if (rd !== 0 || err !== 0 || fl !== 0 || lat !== 1) begin
      failures++;
      $display("FAIL addr_unimpl rdata=%h err=%0b flush=%0d lat=%0d want 0 0 0 1", rd, err, fl, lat);
    end
    model_access(1, CSR_SPMPCFG0 + 12'd4, '1, mrd, merr, mch);
    xact(1, CSR_SPMPCFG0 + 12'd4, '1, 1, rd, err, lat, fl, to, os);
    checks++;
    if (rd !== 0 || err !== 0 || fl !== 0) begin
      failures++;
      $display("FAIL cfg_unimpl rdata=%h err=%0b flush=%0d want 0 0 0", rd, err, fl);
    end
    model_access(1, CSR_SPMPSWITCH, '1, mrd, merr, mch);
    xact(1, CSR_SPMPSWITCH, '1, 1, rd, err, lat, fl, to, os);
    checks++;
    if (rd !== 64'hFFFF || sw_o !== 64'hFFFF) begin
      failures++;
      $display("FAIL switch_mask rdata=%h out=%h want ffff", rd, sw_o);
    end
  endtask

  task automatic test_illegal();
    logic [63:0] rd, mrd; logic err; int lat, fl; bit to, os, merr, mch;
    model_access(1, CSR_SPMPCFG0 + 12'd1, '1, mrd, merr, mch);
    xact(1, CSR_SPMPCFG0 + 12'd1, '1, 1, rd, err, lat, fl, to, os);
    checks++;
    if (err !== 1 || fl !== 0 || lat !== 1 || rd !== 0) begin
      failures++;
      $display("FAIL odd_cfg err=%0b flush=%0d lat=%0d rdata=%h want 1 0 1 0", err, fl, lat, rd);
    end
    checks++;
    if (!outputs_match() || !os) begin
      failures++;
      $display("FAIL odd_cfg_state outputs_ok=%0b idle_after=%0b want 1 1", outputs_match(), os);
    end
    xact(0, 12'h000, 64'h0, 1, rd, err, lat, fl, to, os);
    checks++;
    if (err !== 1 || to) begin
      failures++;
      $display("FAIL unmapped err=%0b timeout=%0b want err=1", err, to);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] rd, mrd; logic err; int lat, fl; bit to, os, merr, mch;
    model_access(0, CSR_SPMPCFG0, 64'h0, mrd, merr, mch);
    flush_ack = 1;
    xact(0, CSR_SPMPCFG0, 64'h0, 1, rd, err, lat, fl, to, os);
    checks++;
    if (lat !== 1 || fl !== 0 || rd !== mrd || !os) begin
      failures++;
      $display("FAIL read_ack_high lat=%0d flush=%0d rdata=%h oneshot=%0b want 1 0 %h 1", lat, fl, rd, os, mrd);
    end
    model_access(1, CSR_SPMPSWITCH, 64'hFFFF, mrd, merr, mch);
    xact(1, CSR_SPMPSWITCH, 64'hFFFF, 1, rd, err, lat, fl, to, os);
    checks++;
    if (mch || fl !== 0 || lat !== 1) begin
      failures++;
      $display("FAIL rewrite_same flush=%0d lat=%0d want 0 1", fl, lat);
    end
  endtask

  task automatic test_random();
    logic [63:0] rd, mrd, wd; logic err; int lat, fl, d; bit to, os, merr, mch, we;
    logic [11:0] a;
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 3))
        0:       a = CSR_SPMPCFG0 + 12'($urandom_range(0, 15));
        1:       a = CSR_SPMPADDR0 + 12'($urandom_range(0, 63));
        2:       a = CSR_SPMPSWITCH;
        default: a = 12'($urandom_range(0, 4095));
      endcase
      we = 1'($urandom_range(0, 1));
      wd = {$urandom, $urandom};
      d  = $urandom_range(1, 4);
      model_access(we, a, wd, mrd, merr, mch);
      xact(we, a, wd, d, rd, err, lat, fl, to, os);
      checks++;
      if (to || rd !== mrd || err !== merr) begin
        failures++;
        $display("FAIL rand_rsp i=%0d addr=%h we=%0b to=%0b rdata=%h err=%0b want %h %0b", i, a, we, to, rd, err, mrd, merr);
      end
      checks++;
      if (lat !== exp_lat(mch, d) || fl !== exp_fl(mch, d) || !os) begin
        failures++;
        $display("FAIL rand_timing i=%0d lat=%0d flush=%0d oneshot=%0b want %0d %0d 1", i, lat, fl, os, exp_lat(mch, d), exp_fl(mch, d));
      end
      checks++;
      if (!outputs_match()) begin
        failures++;
        $display("FAIL rand_outputs i=%0d addr=%h cfg=%h sw=%h want sw=%h", i, a, cfg_o, sw_o, m_sw);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit saw;
    @(negedge clk);
    for (int w = 0; w < 20 && !csr_ready; w++) @(negedge clk);
    csr_valid = 1; csr_we = 1; csr_addr = CSR_SPMPADDR0 + 12'd1; csr_wdata = 64'h1234;
    @(posedge clk);
    #1 csr_valid = 0;
    rst_n = 0;
    saw = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (csr_rsp_valid || flush_req) saw = 1;
    end
    model_clear();
    checks++;
    if (saw || csr_err !== 0 || csr_rdata !== 0) begin
      failures++;
      $display("FAIL reset_mid_rsp saw_rsp_or_flush=%0b err=%0b rdata=%h want 0 0 0", saw, csr_err, csr_rdata);
    end
    checks++;
    if (cfg_o !== '0 || addr_o !== '0 || sw_o !== 0) begin
      failures++;
      $display("FAIL reset_mid_regs cfg=%h addr=%h sw=%h want 0", cfg_o, addr_o, sw_o);
    end
    rst_n = 1;
    @(negedge clk);
    checks++;
    if (csr_ready !== 1 || csr_rsp_valid !== 0) begin
      failures++;
      $display("FAIL reset_mid_ready ready=%0b rsp=%0b want 1 0", csr_ready, csr_rsp_valid);
    end
  endtask

  initial begin
    rst_n = 0; csr_valid = 0; csr_we = 0; csr_addr = '0; csr_wdata = '0; flush_ack = 0;
    model_clear();
    repeat (3) @(posedge clk);
    test_reset();
    test_cfg_write();
    test_warl();
    test_addr();
    test_illegal();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spmp_csr_regs.md
SPMP_CSR_REGS -- requirements
Module: spmp_csr_regs

Interface
REQ-001 SHALL take parameter CVA6Cfg, default config_pkg::cva6_cfg_empty; it supplies the entry count (NrSPMPEntries, 0..64) and the physical address width (PLEN).
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-003 SHALL have port rst_ni, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port csr_valid_i, input, 1 bit: a CSR access request is present.
REQ-005 SHALL have port csr_ready_o, output, 1 bit: the block accepts a request.
REQ-006 SHALL have port csr_we_i, input, 1 bit: 1 = write, 0 = read.
REQ-007 SHALL have port csr_addr_i, input, 12 bits: the CSR address.
REQ-008 SHALL have port csr_wdata_i, input, 64 bits: the write data.
REQ-009 SHALL have port csr_rsp_valid_o, output, 1 bit: a one-cycle response pulse.
REQ-010 SHALL have port csr_rdata_o, output, 64 bits: the read data, valid with csr_rsp_valid_o.
REQ-011 SHALL have port csr_err_o, output, 1 bit: illegal CSR address, valid with csr_rsp_valid_o.
REQ-012 SHALL have port flush_req_o, output, 1 bit: a request to invalidate cached permission results downstream.
REQ-013 SHALL have port flush_ack_i, input, 1 bit: the downstream flush is complete.
REQ-014 SHALL have port spmpcfg_o, output, NrSPMPEntries x spmpcfg_t: the configuration fed to the SPMP checkers.
REQ-015 SHALL have port spmpaddr_o, output, NrSPMPEntries x (PLEN-2) bits: the entry addresses.
REQ-016 SHALL have port spmpswitch_o, output, 64 bits: the per-entry enable bits.

Function
REQ-017 SHALL use the CSR map: spmpcfgN at CSR_SPMPCFG0+N for even N only, each holding 8 cfg bytes for entries 8N/2..8N/2+7; spmpaddrK at CSR_SPMPADDR0+K for K = 0..63; spmpswitch at CSR_SPMPSWITCH.
REQ-018 SHALL use the cfg byte layout bit0=R, bit1=W, bit2=X, bits4:3=addr_mode, bit7=S; bits 6:5 SHALL read as 0.
REQ-019 SHALL treat an odd spmpcfg index or any unmapped address as illegal: no state change, and csr_err_o=1 on the response.
REQ-020 SHALL run a state machine with states IDLE, FLUSH and RESP; csr_ready_o SHALL be 1 only in IDLE.
REQ-021 SHALL, on csr_valid_i & csr_ready_o, commit the write in that cycle, so the new value is visible on the outputs in the next cycle.
REQ-022 SHALL go from IDLE to FLUSH if the accepted write changed any output bit, and otherwise to RESP.
REQ-023 SHALL hold flush_req_o=1 in FLUSH until the cycle flush_ack_i=1, then go to RESP.
REQ-024 SHALL, in RESP, assert csr_rsp_valid_o for exactly one cycle (no backpressure) and then return to IDLE; read latency SHALL therefore be 1 cycle.
REQ-025 SHALL return read data reflecting the state after any write.
REQ-026 SHALL apply WARL per cfg byte: a byte with S=1 and XWR=000 (reserved) SHALL be ignored and that entry SHALL keep its old value; the other bytes in the same write SHALL still update.
REQ-027 SHALL ignore writes to entries at or above NrSPMPEntries, which SHALL read as 0; spmpswitch bits at or above NrSPMPEntries SHALL read as 0.
REQ-028 SHALL discard spmpaddr write bits at position PLEN-2 and above, which SHALL read as 0.
REQ-029 SHALL ignore flush_ack_i outside FLUSH.
REQ-030 SHALL, when NrSPMPEntries=0, make all SPMP CSRs read as 0 without error and ignore writes; spmpswitch_o SHALL be 0.

Reset
REQ-031 SHALL, on rst_ni low, set state=IDLE and clear every spmpcfg_o, spmpaddr_o and spmpswitch_o bit to 0 (all entries OFF and disabled).
REQ-032 SHALL, on rst_ni low, force csr_rsp_valid_o=0, flush_req_o=0, csr_err_o=0 and csr_rdata_o=0.
REQ-033 SHALL, when reset asserts during FLUSH or RESP, abort the transaction and emit no response.

Configuration
REQ-034 SHALL, with macro SPMP_FLUSH_HANDSHAKE_EN defined, implement FLUSH exactly as in REQ-022 and REQ-023.
REQ-035 SHALL, without SPMP_FLUSH_HANDSHAKE_EN, omit the FLUSH state: an effective write SHALL pulse flush_req_o for one cycle concurrent with RESP, flush_ack_i SHALL be unused, and response latency SHALL be fixed at 1 cycle.

Structure
REQ-036 SHALL define spmpcfg_t, CSR_SPMPCFG0, CSR_SPMPADDR0 and CSR_SPMPSWITCH in riscv_pkg, alongside the existing pmp_access_t.
REQ-037 SHALL contain one sub-module, spmp_cfg_warl, which is combinational and computes the legalized next value of one cfg byte from the old and new values.

Verification
REQ-038 SHALL cover: after reset, read spmpswitch -> rsp 1 cycle later, rdata=0, err=0.
REQ-039 SHALL cover: write spmpcfg0=0x0000_0000_0000_8F0B -> entry0 cfg=0x0B and entry1 cfg=0x8F, flush_req_o held until flush_ack_i is driven 3 cycles later, then rsp.
REQ-040 SHALL cover: write cfg byte 0x80 (S=1, XWR=000) to entry2 -> entry2 unchanged and the other bytes updated.
REQ-041 SHALL cover: write spmpaddr0=all-ones with PLEN=34 -> readback=0xFFFFFFFF (bits 63:32 zero).
REQ-042 SHALL cover: access to spmpcfg1 -> err=1, no flush, state unchanged.
REQ-043 SHALL cover: rst_ni asserted mid-FLUSH -> no rsp, all outputs 0, csr_ready_o=1 after reset.
